xintf_ram_arbiter: RTL and testbench
====================================

// Module: xintf_ram_arbiter
// PURPOSE
//  Round-robin arbiter sharing a single XINTF DPBRAM port (addr/din/we/ce) among N_REQ
//  burst requesters, e.g. the periodic status/parameter mirror, the waveform loader and
//  debug access. Grants one requester per burst and registers its beats onto the RAM port.
//  Steers returned read data back to the owning requester.
//  Caps burst length so no requester starves the DSP mirror refresh.
// PARAMETERS
//  N_REQ      3    number of requesters (2..8)
//  ADDR_W     9    DPBRAM address width
//  DATA_W     16   DPBRAM data width
//  MAX_BURST  64   max beats per grant before forced release (1..255)
// PORTS
//  i_clk         in   1               system clock
//  i_rst         in   1               asynchronous active-low reset
//  i_req         in   N_REQ           burst request, held high until burst done
//  o_gnt         out  N_REQ           one-hot grant, registered
//  i_ce          in   N_REQ           beat valid from requester
//  i_we          in   N_REQ           beat is write (1) / read (0)
//  i_last        in   N_REQ           final beat of burst (qualified by i_ce)
//  i_addr        in   N_REQ*ADDR_W    beat address, requester k at [k*ADDR_W +: ADDR_W]
//  i_din         in   N_REQ*DATA_W    beat write data, same packing
//  o_ram_addr    out  ADDR_W          to DPBRAM
//  o_ram_din     out  DATA_W          to DPBRAM
//  o_ram_we      out  1               to DPBRAM
//  o_ram_ce      out  1               to DPBRAM
//  i_ram_dout    in   DATA_W          DPBRAM read data, 1-cycle latency after ce
//  o_rdata       out  DATA_W          = i_ram_dout (shared by all requesters)
//  o_rvalid      out  N_REQ           read data valid for requester k
//  o_force_rel   out  1               1-cycle pulse: burst cut at MAX_BURST
// BEHAVIOUR
//  Reset: o_gnt=0, o_ram_*=0, o_rvalid=0, o_force_rel=0, state=IDLE, beat_cnt=0;
//   last_gnt=N_REQ-1, so requester 0 has top priority after reset. Reset mid-burst aborts silently.
//  FSM IDLE->GRANT->RELEASE->IDLE:
//   IDLE: if |i_req, pick first set bit scanning from last_gnt+1 (mod N_REQ); next cycle
//    o_gnt[g]=1, last_gnt=g, beat_cnt=0, state=GRANT. No req: stay IDLE.
//   GRANT: beat = i_ce[g]&o_gnt[g]. At beat cycle t: o_ram_addr/din/we from slot g and
//    o_ram_ce=1 at t+1; no beat -> o_ram_ce=0, o_ram_we=0, addr/din hold.
//    beat_cnt += 1 per beat.
//    Exit to RELEASE (o_gnt cleared same edge) when any of:
//     beat with i_last[g]; i_req[g]=0 (no error); beat_cnt reaches MAX_BURST
//     (o_force_rel pulses one cycle).
//    Exit-edge beat is still issued.
//   RELEASE: one idle cycle, o_gnt=0, beat_cnt=0; then IDLE. Guarantees >=1 dead cycle between owners.
//  i_ce/i_we/i_last from non-granted requesters ignored; no RAM access.
//  Read return: read beat at t -> o_rvalid[g]=1 at t+2 with o_rdata valid; tag pipeline is
//   independent of FSM, so reads issued on exit beat still return after o_gnt drops.
//  Back-to-back beats every cycle supported; throughput 1 beat/clk inside grant.
//  Requests arriving during GRANT/RELEASE wait; evaluated in IDLE only.
//  Single requester re-requesting: re-granted after RELEASE+IDLE (grant gap 2 cycles).
// TESTING
//  1 reset, req=3'b111 -> gnt order 001,010,100,001 (each 4-beat burst, i_last on 4th).
//  2 req0 writes addr 0..42 data=addr+16'h100 -> o_ram_ce 43 cycles, addr/din match, 1 clk lag.
//  3 req1 read burst addr 5..7, RAM model returns addr*2 -> o_rvalid[1] 3 clks, rdata 10,12,14.
//  4 req2 holds req, ce every clk, no last -> 64 beats, o_force_rel pulse, gnt2 drops.
//  5 req0 granted, drop req after 2 beats; req1 ce while ungranted -> 2 RAM ops, none from req1.
//  6 assert i_rst low mid-burst at beat 10 -> all outputs 0 next edge; after release req0 granted first.

Source files
------------

// File: rtl/xintf_ram_arbiter.sv
// Round-robin arbiter sharing one XINTF DPBRAM port among N_REQ burst requesters.
// Grants one requester per burst, registers its beats onto the RAM port and steers read data back.
module xintf_ram_arbiter #(
    parameter int N_REQ     = 3,
    parameter int ADDR_W    = 9,
    parameter int DATA_W    = 16,
    parameter int MAX_BURST = 64
) (
    input  logic                      i_clk,
    input  logic                      i_rst,
    input  logic [N_REQ-1:0]          i_req,
    output logic [N_REQ-1:0]          o_gnt,
    input  logic [N_REQ-1:0]          i_ce,
    input  logic [N_REQ-1:0]          i_we,
    input  logic [N_REQ-1:0]          i_last,
    input  logic [N_REQ*ADDR_W-1:0]   i_addr,
    input  logic [N_REQ*DATA_W-1:0]   i_din,
    output logic [ADDR_W-1:0]         o_ram_addr,
    output logic [DATA_W-1:0]         o_ram_din,
    output logic                      o_ram_we,
    output logic                      o_ram_ce,
    input  logic [DATA_W-1:0]         i_ram_dout,
    output logic [DATA_W-1:0]         o_rdata,
    output logic [N_REQ-1:0]          o_rvalid,
    output logic                      o_force_rel
);

    localparam int IDX_W = $clog2(N_REQ);
    localparam int CNT_W = 8;

    typedef enum logic [1:0] {
        S_IDLE,
        S_GRANT,
        S_RELEASE
    } state_t;

    state_t              state_q, state_d;
    logic [N_REQ-1:0]    gnt_q, gnt_d;
    logic [IDX_W-1:0]    gnt_idx_q, gnt_idx_d;   // doubles as last_gnt for the round-robin scan
    logic [CNT_W-1:0]    beat_cnt_q, beat_cnt_d;
    logic                force_rel_q, force_rel_d;
    logic [ADDR_W-1:0]   ram_addr_q, ram_addr_d;
    logic [DATA_W-1:0]   ram_din_q, ram_din_d;
    logic                ram_we_q, ram_we_d;
    logic                ram_ce_q, ram_ce_d;
    logic [N_REQ-1:0]    rd_tag_q, rd_tag_d;
    logic [N_REQ-1:0]    rvalid_q, rvalid_d;

    logic                pick_valid;
    logic [IDX_W-1:0]    pick_idx;
    logic                sel_ce, sel_we, sel_last, sel_req;
    logic [ADDR_W-1:0]   sel_addr;
    logic [DATA_W-1:0]   sel_din;
    logic                beat, last_hit, cap_hit;

    // Round-robin pick: first set request scanning upward from last_gnt+1, wrapping.
    always_comb begin
        int cand;
        pick_valid = 1'b0;
        pick_idx   = gnt_idx_q;
        cand       = 0;
        for (int off = 1; off <= N_REQ; off++) begin
            cand = (int'(gnt_idx_q) + off) % N_REQ;
            if (!pick_valid && i_req[cand]) begin
                pick_valid = 1'b1;
                pick_idx   = IDX_W'(cand);
            end
        end
    end

    assign sel_ce   = i_ce[gnt_idx_q];
    assign sel_we   = i_we[gnt_idx_q];
    assign sel_last = i_last[gnt_idx_q];
    assign sel_req  = i_req[gnt_idx_q];
    assign sel_addr = i_addr[gnt_idx_q*ADDR_W +: ADDR_W];
    assign sel_din  = i_din[gnt_idx_q*DATA_W +: DATA_W];

    assign beat     = (state_q == S_GRANT) && sel_ce && gnt_q[gnt_idx_q];
    assign last_hit = beat && sel_last;
    assign cap_hit  = beat && ((int'(beat_cnt_q) + 1) == MAX_BURST);

    // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latch).
    always_comb begin
        state_d     = state_q;
        gnt_d       = gnt_q;
        gnt_idx_d   = gnt_idx_q;
        beat_cnt_d  = beat_cnt_q;
        force_rel_d = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                gnt_d      = '0;
                beat_cnt_d = '0;
                if (pick_valid) begin
                    state_d   = S_GRANT;
                    gnt_d     = N_REQ'(1) << pick_idx;
                    gnt_idx_d = pick_idx;
                end
            end
            S_GRANT: begin
                if (beat) beat_cnt_d = beat_cnt_q + CNT_W'(1);
                if (last_hit || !sel_req || cap_hit) begin
                    state_d     = S_RELEASE;
                    gnt_d       = '0;
                    force_rel_d = cap_hit && !last_hit;
                end
            end
            S_RELEASE: begin
                state_d    = S_IDLE;
                gnt_d      = '0;
                beat_cnt_d = '0;
            end
            default: begin
                state_d    = S_IDLE;
                gnt_d      = '0;
                beat_cnt_d = '0;
            end
        endcase
    end

    // RAM port and read-return tag pipeline run independently of the FSM state.
    always_comb begin
        ram_ce_d   = beat;
        ram_we_d   = beat && sel_we;
        ram_addr_d = beat ? sel_addr : ram_addr_q;
        ram_din_d  = beat ? sel_din  : ram_din_q;
        rd_tag_d   = (beat && !sel_we) ? gnt_q : '0;
        rvalid_d   = rd_tag_q;
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            state_q     <= S_IDLE;
            gnt_q       <= '0;
            gnt_idx_q   <= IDX_W'(N_REQ - 1);
            beat_cnt_q  <= '0;
            force_rel_q <= 1'b0;
            ram_addr_q  <= '0;
            ram_din_q   <= '0;
            ram_we_q    <= 1'b0;
            ram_ce_q    <= 1'b0;
            rd_tag_q    <= '0;
            rvalid_q    <= '0;
        end else begin
            state_q     <= state_d;
            gnt_q       <= gnt_d;
            gnt_idx_q   <= gnt_idx_d;
            beat_cnt_q  <= beat_cnt_d;
            force_rel_q <= force_rel_d;
            ram_addr_q  <= ram_addr_d;
            ram_din_q   <= ram_din_d;
            ram_we_q    <= ram_we_d;
            ram_ce_q    <= ram_ce_d;
            rd_tag_q    <= rd_tag_d;
            rvalid_q    <= rvalid_d;
        end
    end

    assign o_gnt       = gnt_q;
    assign o_force_rel = force_rel_q;
    assign o_ram_addr  = ram_addr_q;
    assign o_ram_din   = ram_din_q;
    assign o_ram_we    = ram_we_q;
    assign o_ram_ce    = ram_ce_q;
    assign o_rvalid    = rvalid_q;
    assign o_rdata     = i_ram_dout;

endmodule

// File: tb/tb_xintf_ram_arbiter.sv
// Directed bench for xintf_ram_arbiter: round-robin order, write/read bursts, burst cap,
// request drop, ungranted isolation and mid-burst reset, with a 1-cycle-latency RAM model.
module tb_xintf_ram_arbiter;

    localparam int N_REQ  = 3;
    localparam int ADDR_W = 9;
    localparam int DATA_W = 16;

    logic                    clk = 1'b0;
    logic                    rst_n;
    logic [N_REQ-1:0]        req, ce, we, last;
    logic [N_REQ*ADDR_W-1:0] addr;
    logic [N_REQ*DATA_W-1:0] din;
    logic [N_REQ-1:0]        gnt, rvalid;
    logic [ADDR_W-1:0]       ram_addr;
    logic [DATA_W-1:0]       ram_din, ram_dout, rdata;
    logic                    ram_we, ram_ce, force_rel;

    int n_checks = 0;
    int n_pass   = 0;

    logic [ADDR_W-1:0] op_addr[$];
    logic [DATA_W-1:0] rd_log[$];
    logic [N_REQ-1:0]  gnt_log[$];
    logic [N_REQ-1:0]  prev_gnt = '0;
    int                rv_other = 0;
    int                fr_cnt   = 0;

    xintf_ram_arbiter #(.N_REQ(N_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_BURST(64)) dut (
        .i_clk       (clk),
        .i_rst       (rst_n),
        .i_req       (req),
        .o_gnt       (gnt),
        .i_ce        (ce),
        .i_we        (we),
        .i_last      (last),
        .i_addr      (addr),
        .i_din       (din),
        .o_ram_addr  (ram_addr),
        .o_ram_din   (ram_din),
        .o_ram_we    (ram_we),
        .o_ram_ce    (ram_ce),
        .i_ram_dout  (ram_dout),
        .o_rdata     (rdata),
        .o_rvalid    (rvalid),
        .o_force_rel (force_rel)
    );

    always #5 clk = ~clk;

    // RAM model: a read of address a returns a*2 one cycle after ce.
    initial ram_dout = '0;
    always @(posedge clk) begin
        if (ram_ce && !ram_we) ram_dout <= DATA_W'(ram_addr) << 1;
    end

    always @(negedge clk) begin
        if (ram_ce) op_addr.push_back(ram_addr);
        if (rvalid[1]) rd_log.push_back(rdata);
        if ((rvalid & 3'b101) != 3'b000) rv_other++;
        if (force_rel) fr_cnt++;
        if (gnt != '0 && prev_gnt == '0) gnt_log.push_back(gnt);
        prev_gnt = gnt;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic wait_gnt(input int k);
        int n;
        n = 0;
        while (gnt[k] !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        check("wait_gnt", 32'(gnt[k]), 32'd1);
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_gnt"},    32'(gnt),       32'd0);
        check({tag, "_ce"},     32'(ram_ce),    32'd0);
        check({tag, "_we"},     32'(ram_we),    32'd0);
        check({tag, "_addr"},   32'(ram_addr),  32'd0);
        check({tag, "_din"},    32'(ram_din),   32'd0);
        check({tag, "_rvalid"}, 32'(rvalid),    32'd0);
        check({tag, "_frel"},   32'(force_rel), 32'd0);
    endtask

    initial begin
        logic [N_REQ-1:0] exp_order [4];
        int order [4];
        int n;
        exp_order = '{3'b001, 3'b010, 3'b100, 3'b001};
        order     = '{0, 1, 2, 0};

        rst_n = 1'b0;
        req = '0; ce = '0; we = '0; last = '0; addr = '0; din = '0;
        tick();
        tick();
        check_outputs_zero("reset");
        rst_n = 1'b1;
        tick();

        // 1: all three request; 4-beat bursts in round-robin order starting at 0
        gnt_log.delete();
        req = 3'b111;
        for (int b = 0; b < 4; b++) begin
            wait_gnt(order[b]);
            for (int i = 0; i < 4; i++) begin
                ce[order[b]] = 1'b1;
                we[order[b]] = 1'b1;
                last[order[b]] = (i == 3);
                addr[order[b]*ADDR_W +: ADDR_W] = ADDR_W'(i);
                tick();
            end
            ce = '0; we = '0; last = '0;
        end
        req = '0;
        tick();
        check("rr_count", 32'(gnt_log.size()), 32'd4);
        for (int i = 0; i < 4; i++)
            check("rr_order", 32'((gnt_log.size() > i) ? gnt_log[i] : 3'bxxx), 32'(exp_order[i]));

        // 2: requester 0 writes 43 beats, RAM port follows one clock later
        tick();
        op_addr.delete();
        req[0] = 1'b1;
        wait_gnt(0);
        check("wr_ce_before", 32'(ram_ce), 32'd0);
        for (int i = 0; i < 43; i++) begin
            ce[0] = 1'b1; we[0] = 1'b1; last[0] = (i == 42);
            addr[0 +: ADDR_W] = ADDR_W'(i);
            din[0 +: DATA_W]  = DATA_W'(i) + 16'h0100;
            tick();
            check("wr_ce",   32'(ram_ce),   32'd1);
            check("wr_addr", 32'(ram_addr), 32'(i));
            check("wr_din",  32'(ram_din),  32'(i + 16'h0100));
        end
        ce = '0; we = '0; last = '0; req = '0;
        tick();
        check("wr_ce_after", 32'(ram_ce), 32'd0);
        check("wr_ops", 32'(op_addr.size()), 32'd43);

        // 3: requester 1 reads 5..7; model returns 10,12,14 two clocks after each beat
        tick();
        rd_log.delete();
        rv_other = 0;
        req[1] = 1'b1;
        wait_gnt(1);
        for (int i = 0; i < 3; i++) begin
            ce[1] = 1'b1; we[1] = 1'b0; last[1] = (i == 2);
            addr[ADDR_W +: ADDR_W] = ADDR_W'(5 + i);
            tick();
            if (i == 0) check("rd_lat1", 32'(rvalid), 32'd0);
            if (i == 1) begin
                check("rd_lat2_v", 32'(rvalid), 32'b010);
                check("rd_lat2_d", 32'(rdata),  32'd10);
            end
        end
        ce = '0; last = '0; req = '0;
        tick(); tick(); tick();
        check("rd_count", 32'(rd_log.size()), 32'd3);
        check("rd_d0", 32'((rd_log.size() > 0) ? rd_log[0] : 16'hxxxx), 32'd10);
        check("rd_d1", 32'((rd_log.size() > 1) ? rd_log[1] : 16'hxxxx), 32'd12);
        check("rd_d2", 32'((rd_log.size() > 2) ? rd_log[2] : 16'hxxxx), 32'd14);
        check("rd_other", 32'(rv_other), 32'd0);

        // 4: requester 2 streams without last; cut after 64 beats
        op_addr.delete();
        req[2] = 1'b1;
        wait_gnt(2);
        n = 0;
        while (gnt[2] === 1'b1 && n < 100) begin
            ce[2] = 1'b1; we[2] = 1'b1;
            addr[2*ADDR_W +: ADDR_W] = ADDR_W'(n);
            tick();
            n++;
        end
        check("cap_beats", 32'(n), 32'd64);
        check("cap_frel",  32'(force_rel), 32'd1);
        check("cap_gnt",   32'(gnt), 32'd0);
        ce = '0; we = '0; req = '0;
        tick();
        check("cap_frel_pulse", 32'(force_rel), 32'd0);
        check("cap_ops",  32'(op_addr.size()), 32'd64);
        check("cap_frel_cnt", 32'(fr_cnt), 32'd1);

        // 5: requester 0 drops req after 2 beats; ungranted requester 1 strobes ce throughout
        tick();
        op_addr.delete();
        ce[1] = 1'b1; we[1] = 1'b1;
        addr[ADDR_W +: ADDR_W] = 9'h1FF;
        req[0] = 1'b1;
        wait_gnt(0);
        check("drop_gnt", 32'(gnt), 32'b001);
        for (int i = 0; i < 2; i++) begin
            ce[0] = 1'b1; we[0] = 1'b1;
            addr[0 +: ADDR_W] = ADDR_W'(9'h30 + i);
            tick();
        end
        ce[0] = 1'b0; we[0] = 1'b0; req[0] = 1'b0;
        tick();
        check("drop_gnt_off", 32'(gnt), 32'd0);
        check("drop_frel",    32'(force_rel), 32'd0);
        tick(); tick();
        ce = '0; we = '0;
        check("drop_ops", 32'(op_addr.size()), 32'd2);
        check("drop_a0", 32'((op_addr.size() > 0) ? op_addr[0] : 9'hxxx), 32'h30);
        check("drop_a1", 32'((op_addr.size() > 1) ? op_addr[1] : 9'hxxx), 32'h31);
        check("drop_frel_cnt", 32'(fr_cnt), 32'd1);

        // 6: reset during a read burst at beat 10, then requester 0 wins first
        req = 3'b010;
        wait_gnt(1);
        for (int i = 0; i < 10; i++) begin
            ce[1] = 1'b1; we[1] = 1'b0;
            addr[ADDR_W +: ADDR_W] = ADDR_W'(i);
            tick();
        end
        check("pre_rst_ce", 32'(ram_ce), 32'd1);
        rst_n = 1'b0;
        #1;
        check_outputs_zero("mid_rst");
        ce = '0;
        req = 3'b111;
        tick();
        check_outputs_zero("mid_rst_edge");
        rst_n = 1'b1;
        wait_gnt(0);
        check("post_rst_gnt", 32'(gnt), 32'b001);
        req = '0;
        tick();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
